// File: rtl/sar_busca_4bit.sv
// Successive-approximation search controller that drives comparador_4bit and recovers B.
// Optional pass counter on the passos output is enabled by defining SAR_PASSOS_EN.
module sar_busca_4bit #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         igual,
  input  logic         maior,
  input  logic         menor,
  output logic [N-1:0] candidato,
  output logic [N-1:0] valor,
  output logic         ocupado,
  output logic         pronto,
  output logic         erro,
  output logic [2:0]   passos
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    TESTA  = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  cand_q, cand_d, cand_upd;
  logic [N-1:0]  valor_q, valor_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          erro_q, erro_d;
  logic          flags_ok;
  logic          start;

  assign flags_ok = ({igual, maior, menor} == 3'b100) ||
                    ({igual, maior, menor} == 3'b010) ||
                    ({igual, maior, menor} == 3'b001);
  // iniciar is ignored while a search is in progress.
  assign start    = iniciar && (state_q != TESTA);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO, FIM: if (iniciar) state_d = TESTA;
      TESTA:       if (!flags_ok || igual || (idx_q == '0)) state_d = FIM;
      default:     state_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (state_q == TESTA);
    pronto  = (state_q == FIM);
  end

  // Datapath: resolve bit idx from the flags, then probe the next lower bit.
  always_comb begin
    cand_upd = maior ? (cand_q & ~(ONE << idx_q)) : cand_q;
    cand_d   = cand_q;
    valor_d  = valor_q;
    idx_d    = idx_q;
    erro_d   = erro_q;
    if (start) begin
      cand_d  = ONE << (N-1);
      idx_d   = IW'(N-1);
      erro_d  = 1'b0;
      valor_d = '0;
    end else if (state_q == TESTA) begin
      if (!flags_ok) begin
        erro_d  = 1'b1;
        valor_d = '0;
      end else if (igual) begin
        valor_d = cand_q;
      end else if (idx_q == '0) begin
        cand_d  = cand_upd;
        valor_d = cand_upd;
      end else begin
        cand_d  = cand_upd | (ONE << (idx_q - 1'b1));
        idx_d   = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q  <= '0;
      valor_q <= '0;
      idx_q   <= IW'(N-1);
      erro_q  <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      valor_q <= valor_d;
      idx_q   <= idx_d;
      erro_q  <= erro_d;
    end
  end

  assign candidato = cand_q;
  assign valor     = valor_q;
  assign erro      = erro_q;

`ifdef SAR_PASSOS_EN
  logic [2:0] passos_q, passos_d;

  always_comb begin
    passos_d = passos_q;
    if (start)                                        passos_d = 3'd0;
    else if ((state_q == TESTA) && (passos_q != 3'd7)) passos_d = passos_q + 3'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) passos_q <= 3'd0;
    else       passos_q <= passos_d;
  end

  assign passos = passos_q;
`else
  assign passos = 3'b000;
`endif

endmodule

// File: tb/tb_sar_busca_4bit.sv
// Self-checking bench for sar_busca_4bit with a behavioural comparator and binary-search model.
module tb_sar_busca_4bit;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar;
  logic         igual, maior, menor;
  logic [N-1:0] candidato, valor;
  logic         ocupado, pronto, erro;
  logic [2:0]   passos;

  logic [N-1:0] b;
  logic         force_bad;
  int           checks = 0;
  int           errors = 0;

  sar_busca_4bit #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .igual     (igual),
    .maior     (maior),
    .menor     (menor),
    .candidato (candidato),
    .valor     (valor),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro),
    .passos    (passos)
  );

  always #5 clock = ~clock;

  // Behavioural comparador_4bit; force_bad presents an illegal igual+maior pattern.
  assign igual = force_bad ? 1'b1 : (candidato == b);
  assign maior = force_bad ? 1'b1 : (candidato >  b);
  assign menor = force_bad ? 1'b0 : (candidato <  b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_passos(input int steps);
`ifdef SAR_PASSOS_EN
    return (steps > 7) ? 7 : steps;
`else
    return 0;
`endif
  endfunction

  // Probe k keeps B's bits above k and sets bit k; stop on equality or after bit 0.
  task automatic search(input logic [N-1:0] bv, input bit poke_start);
    int seq[$];
    int bi;
    int i;
    bi = int'(bv);
    for (int k = N-1; k >= 0; k--) begin
      int c;
      c = ((bi >> (k+1)) << (k+1)) | (1 << k);
      seq.push_back(c);
      if (c == bi) break;
    end
    b = bv;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("start_pronto_low", pronto, 0);
    check("start_erro_clear", erro, 0);
    check("start_passos_zero", passos, 0);
    i = 0;
    while ((ocupado === 1'b1) && (i < 8)) begin
      if (i < seq.size()) check($sformatf("cand_b%0d_s%0d", bi, i), candidato, seq[i]);
      else                check("extra_testa", ocupado, 0);
      if (poke_start) iniciar = 1'($urandom_range(0, 1));
      i++;
      @(negedge clock);
    end
    iniciar = 1'b0;
    check($sformatf("steps_b%0d", bi), i, seq.size());
    check($sformatf("pronto_b%0d", bi), pronto, 1);
    check($sformatf("valor_b%0d", bi), valor, bi);
    check($sformatf("erro_b%0d", bi), erro, 0);
    check($sformatf("passos_b%0d", bi), passos, exp_passos(seq.size()));
    @(negedge clock);
    check("pronto_hold", pronto, 1);
    check("valor_hold", valor, bi);
  endtask

  initial begin
    reset     = 1'b1;
    iniciar   = 1'b0;
    force_bad = 1'b0;
    b         = '0;
    #1;
    check("rst_candidato", candidato, 0);
    check("rst_valor", valor, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_erro", erro, 0);
    check("rst_passos", passos, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_ocupado", ocupado, 0);
    check("idle_pronto", pronto, 0);

    // Directed cases: mixed result, all-maior, all-menor with igual on the last probe.
    search(4'b1010, 1'b0);
    search(4'b0000, 1'b0);
    search(4'b1111, 1'b0);

    // Illegal flags during TESTA end the search with erro.
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar   = 1'b0;
    force_bad = 1'b1;
    @(negedge clock);
    force_bad = 1'b0;
    check("bad_erro", erro, 1);
    check("bad_valor", valor, 0);
    check("bad_pronto", pronto, 1);
    check("bad_ocupado", ocupado, 0);
    search(4'b0110, 1'b0);

    // Asynchronous reset on the second TESTA cycle aborts the search.
    b = 4'b0101;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    check("abort_in_testa", ocupado, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_candidato", candidato, 0);
    check("abort_valor", valor, 0);
    check("abort_ocupado", ocupado, 0);
    check("abort_pronto", pronto, 0);
    check("abort_erro", erro, 0);
    check("abort_passos", passos, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_stay_idle", ocupado, 0);
    check("abort_no_pronto", pronto, 0);

    // Exhaustive sweep, then random targets with iniciar toggled during TESTA.
    for (int v = 0; v < 16; v++) search(4'(v), 1'b0);
    for (int r = 0; r < 20; r++) search(4'($urandom_range(0, 15)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
